// File: rtl/uart_pkg.sv
// Shared types and frame constants for the arbitrated UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  localparam int   FRAME_BITS  = 10;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles while enabled and flags the
// last cycle of each bit period with a one-cycle bit_done pulse.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic en,
  input  logic clr,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_done = en && !clr && (cnt_q == LAST);

  // Next count: clear wins, otherwise advance and wrap at the end of a bit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)           cnt_d = '0;
    else if (bit_done) cnt_d = '0;
    else if (en)       cnt_d = cnt_q + 1'b1;
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge gclk) begin
    if (!grst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a single 8N1 UART transmitter. One byte is
// accepted per frame; the frame is shifted out LSB first from a register
// so the TX pin never glitches.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       O
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [FRAME_BITS-1:0]   sh_q, sh_d;
  logic [3:0]              bit_q, bit_d;
  logic [NUM_REQ-1:0]      ready;
  logic [IDX_W-1:0]        sel;
  logic                    found;
  logic                    accept;
  logic                    bit_done;
  logic [DATA_W-1:0]       sel_byte;

  // Round-robin search from ptr; ready only offered while idle and out of reset.
  always_comb begin
    int idx;
    idx   = 0;
    ready = '0;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel   = IDX_W'(idx);
      end
    end
    if (found && (state_q == IDLE) && RESET) ready[sel] = 1'b1;
  end

  assign accept   = |ready;
  assign sel_byte = req_data[int'(sel)*DATA_W +: DATA_W];

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .gclk    (CLK),
    .grst_n  (RESET),
    .en      (state_q != IDLE),
    .clr     (accept),
    .bit_done(bit_done)
  );

  // Frame sequencing: load the whole frame on accept, shift once per bit period.
  always_comb begin
    logic [3:0] nb;
    nb      = bit_q + 4'd1;
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sh_d    = {STOP_LEVEL, sel_byte, START_LEVEL};
          grant_d = sel;
          ptr_d   = (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
          bit_d   = '0;
          state_d = START;
        end
      end
      default: begin
        if (bit_done) begin
          sh_d = {IDLE_LEVEL, sh_q[FRAME_BITS-1:1]};
          if (bit_q == 4'(FRAME_BITS - 1)) begin
            bit_d   = '0;
            state_d = IDLE;
          end else begin
            bit_d   = nb;
            state_d = (nb == 4'(FRAME_BITS - 1)) ? STOP : DATA;
          end
        end
      end
    endcase
  end

  // State registers; reset aborts any frame and parks the line high.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      sh_q    <= '1;
      bit_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  assign O         = sh_q[0];
  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_q;
  assign req_ready = ready;

endmodule
